// File: rtl/wb_uart_slave.sv
// Wishbone classic slave exposing an 8N1 UART: status, data and baud-divisor registers,
// a 16x-oversampled transmitter and receiver, and a receive-available interrupt.
module wb_uart_slave #(
   parameter int unsigned CLK_FREQ = 50000000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   input  logic        uart_rxd,
   output logic        uart_txd,
   output logic        rx_irq
);
   localparam int unsigned DIV_RST_INT = CLK_FREQ / (16 * BAUD) - 1;
   localparam logic [15:0] DIV_RST     = DIV_RST_INT[15:0];

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

   logic        ack_q, ack_d;
   logic [31:0] dat_o_q, dat_o_d;
   logic [15:0] div_q, div_d, cnt_q, cnt_d;
   tx_state_t   tx_state_q, tx_state_d;
   logic [3:0]  tx_tcnt_q, tx_tcnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        txd_q, txd_d;
   logic        rxd_s1_q, rxd_s2_q;
   rx_state_t   rx_state_q, rx_state_d;
   logic [3:0]  rx_tcnt_q, rx_tcnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
   logic        avail_q, avail_d, overrun_q, overrun_d, frame_err_q, frame_err_d;

   logic req, tx_busy, tick, stall, access;
   logic wr_data, wr_div, rd_status, rd_data;

   // A DATA write while the transmitter is busy is stalled rather than dropped.
   assign req       = wb_cyc_i & wb_stb_i;
   assign tx_busy   = (tx_state_q != TX_IDLE);
   assign tick      = (cnt_q == 16'd0);
   assign stall     = wb_we_i & (wb_adr_i[3:2] == 2'd1) & tx_busy;
   assign access    = req & ~ack_q & ~stall;
   assign wr_data   = access &  wb_we_i & (wb_adr_i[3:2] == 2'd1);
   assign wr_div    = access &  wb_we_i & (wb_adr_i[3:2] == 2'd2);
   assign rd_status = access & ~wb_we_i & (wb_adr_i[3:2] == 2'd0);
   assign rd_data   = access & ~wb_we_i & (wb_adr_i[3:2] == 2'd1);

   logic unused_ok;
   assign unused_ok = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16]};

   always_comb begin
      // NOTE: every _d starts from a default so no branch can infer a latch.
      ack_d       = access;
      dat_o_d     = '0;
      div_d       = div_q;
      cnt_d       = tick ? div_q : cnt_q - 16'd1;
      tx_state_d  = tx_state_q;
      tx_tcnt_d   = tx_tcnt_q;
      tx_bit_d    = tx_bit_q;
      tx_shift_d  = tx_shift_q;
      txd_d       = txd_q;
      rx_state_d  = rx_state_q;
      rx_tcnt_d   = rx_tcnt_q;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_byte_d   = rx_byte_q;
      avail_d     = avail_q;
      overrun_d   = overrun_q;
      frame_err_d = frame_err_q;

      if (access && !wb_we_i) begin
         case (wb_adr_i[3:2])
            2'd0:    dat_o_d = {28'd0, frame_err_q, overrun_q, tx_busy, avail_q};
            2'd1:    dat_o_d = {24'd0, rx_byte_q};
            2'd2:    dat_o_d = {16'd0, div_q};
            default: dat_o_d = '0;
         endcase
      end
      if (wr_div) begin
         div_d = wb_dat_i[15:0];
         cnt_d = wb_dat_i[15:0];
      end

      case (tx_state_q)
         TX_IDLE: if (wr_data) begin
            tx_state_d = TX_START;
            tx_tcnt_d  = 4'd0;
            tx_shift_d = wb_dat_i[7:0];
            txd_d      = 1'b0;
         end
         TX_START: if (tick) begin
            tx_tcnt_d = tx_tcnt_q + 4'd1;
            if (tx_tcnt_q == 4'd15) begin
               tx_state_d = TX_DATA;
               tx_bit_d   = 3'd0;
               txd_d      = tx_shift_q[0];
            end
         end
         TX_DATA: if (tick) begin
            tx_tcnt_d = tx_tcnt_q + 4'd1;
            if (tx_tcnt_q == 4'd15) begin
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               tx_bit_d   = tx_bit_q + 3'd1;
               txd_d      = tx_shift_q[1];
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TX_STOP;
                  txd_d      = 1'b1;
               end
            end
         end
         default: if (tick) begin
            tx_tcnt_d = tx_tcnt_q + 4'd1;
            if (tx_tcnt_q == 4'd15) tx_state_d = TX_IDLE;
         end
      endcase

      // Host clears come first so a same-edge receive event wins.
      if (rd_data)   avail_d = 1'b0;
      if (rd_status) begin
         overrun_d   = 1'b0;
         frame_err_d = 1'b0;
      end
      case (rx_state_q)
         RX_IDLE: if (tick && !rxd_s2_q) begin
            rx_state_d = RX_START;
            rx_tcnt_d  = 4'd0;
         end
         RX_START: if (tick) begin
            rx_tcnt_d = rx_tcnt_q + 4'd1;
            if (rx_tcnt_q == 4'd7) begin
               rx_tcnt_d  = 4'd0;
               rx_bit_d   = 3'd0;
               rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: if (tick) begin
            rx_tcnt_d = rx_tcnt_q + 4'd1;
            if (rx_tcnt_q == 4'd15) begin
               rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
         end
         RX_STOP: if (tick) begin
            rx_tcnt_d = rx_tcnt_q + 4'd1;
            if (rx_tcnt_q == 4'd15) begin
               if (rxd_s2_q) begin
                  rx_byte_d  = rx_shift_q;
                  avail_d    = 1'b1;
                  if (avail_q && !rd_data) overrun_d = 1'b1;
                  rx_state_d = RX_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  rx_state_d  = RX_BREAK;
               end
            end
         end
         default: if (rxd_s2_q) rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ack_q       <= 1'b0;
         dat_o_q     <= '0;
         div_q       <= DIV_RST;
         cnt_q       <= '0;
         tx_state_q  <= TX_IDLE;
         tx_tcnt_q   <= '0;
         tx_bit_q    <= '0;
         tx_shift_q  <= '0;
         txd_q       <= 1'b1;
         rxd_s1_q    <= 1'b1;
         rxd_s2_q    <= 1'b1;
         rx_state_q  <= RX_IDLE;
         rx_tcnt_q   <= '0;
         rx_bit_q    <= '0;
         rx_shift_q  <= '0;
         rx_byte_q   <= '0;
         avail_q     <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         ack_q       <= ack_d;
         dat_o_q     <= dat_o_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         tx_state_q  <= tx_state_d;
         tx_tcnt_q   <= tx_tcnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_shift_q  <= tx_shift_d;
         txd_q       <= txd_d;
         rxd_s1_q    <= uart_rxd;
         rxd_s2_q    <= rxd_s1_q;
         rx_state_q  <= rx_state_d;
         rx_tcnt_q   <= rx_tcnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
         rx_byte_q   <= rx_byte_d;
         avail_q     <= avail_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_o_q;
   assign uart_txd = txd_q;
   assign rx_irq   = avail_q;
endmodule

// File: tb/tb_wb_uart_slave.sv
// Directed bench for wb_uart_slave: register vector table plus hand-written TX/RX frame sequences.
module tb_wb_uart_slave;
   logic        clk = 1'b0;
   logic        reset;
   logic        wb_cyc_i, wb_stb_i, wb_we_i;
   logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_ack_o;
   logic        uart_rxd, uart_txd, rx_irq;

   int n_checks = 0;
   int n_fail   = 0;

   wb_uart_slave dut (
      .clk(clk), .reset(reset),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
      .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
      .uart_rxd(uart_rxd), .uart_txd(uart_txd), .rx_irq(rx_irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] wdat;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // One Wishbone transfer; cycles = negedges from request until ack is seen.
   task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                       output logic [31:0] rdat, output int cycles);
      @(negedge clk);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = wdat;
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!wb_ack_o && cycles < 2000);
      check("ack_seen", {31'd0, wb_ack_o}, 32'd1);
      rdat = wb_dat_o;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
   endtask

   task automatic rd(input logic [31:0] adr, input string name, input logic [31:0] exp);
      logic [31:0] d;
      int c;
      xfer(1'b0, adr, 32'd0, d, c);
      check(name, d, exp);
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] wdat);
      logic [31:0] d;
      int c;
      xfer(1'b1, adr, wdat, d, c);
      check("write_ack_latency", c, 32'd1);
   endtask

   // Called on the negedge right after the load edge; checks both ends of every bit window.
   task automatic tx_expect(input logic [7:0] b, input string tag);
      logic [9:0] frame;
      frame = {1'b1, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         check($sformatf("%s_bit%0d_first", tag, k), {31'd0, uart_txd}, {31'd0, frame[k]});
         repeat (15) @(negedge clk);
         check($sformatf("%s_bit%0d_last", tag, k), {31'd0, uart_txd}, {31'd0, frame[k]});
         @(negedge clk);
      end
   endtask

   // 16 clocks per bit (divisor 0).
   task automatic rx_send(input logic [7:0] b, input logic stop);
      logic [9:0] frame;
      frame = {stop, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         uart_rxd = frame[k];
         repeat (15) @(negedge clk);
      end
      @(negedge clk);
      uart_rxd = 1'b1;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int c;

      vecs[0] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000};
      vecs[1] = '{1'b0, 32'h0000_0008, 32'h0,         32'h0000_001A};
      vecs[2] = '{1'b0, 32'h0000_000C, 32'h0,         32'h0000_0000};
      vecs[3] = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 32'h0};
      vecs[4] = '{1'b0, 32'h0000_000C, 32'h0,         32'h0000_0000};
      vecs[5] = '{1'b1, 32'h0000_0008, 32'h0000_1234, 32'h0};
      vecs[6] = '{1'b0, 32'h8000_0008, 32'h0,         32'h0000_1234};
      vecs[7] = '{1'b0, 32'h0000_0004, 32'h0,         32'h0000_0000};
      vecs[8] = '{1'b1, 32'h0000_0008, 32'hABCD_0000, 32'h0};
      vecs[9] = '{1'b0, 32'h0000_0008, 32'h0,         32'h0000_0000};

      reset = 1'b1;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 4'hF;
      uart_rxd = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_ack",   {31'd0, wb_ack_o}, 32'd0);
      check("reset_dat_o", wb_dat_o, 32'd0);
      check("reset_txd",   {31'd0, uart_txd}, 32'd1);
      check("reset_irq",   {31'd0, rx_irq}, 32'd0);
      reset = 1'b0;

      // Register map, decode and divisor; ends with divisor 0.
      for (int i = 0; i < 10; i++) begin
         xfer(vecs[i].we, vecs[i].adr, vecs[i].wdat, d, c);
         check($sformatf("vec%0d_ack_latency", i), c, 32'd1);
         if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
      end
      @(negedge clk);
      check("ack_single_cycle", {31'd0, wb_ack_o}, 32'd0);

      // TX frame 0xA5 with a concurrent STATUS read mid-frame.
      wr(32'h4, 32'h0000_00A5);
      fork
         tx_expect(8'hA5, "txA5");
         begin
            repeat (40) @(negedge clk);
            rd(32'h0, "tx_busy_mid_frame", 32'h2);
         end
      join
      rd(32'h0, "tx_busy_after_frame", 32'h0);

      // Second write during TX is stalled until the first frame ends.
      wr(32'h4, 32'h0000_0081);
      xfer(1'b1, 32'h4, 32'h0000_003C, d, c);
      check("stalled_write_latency", c, 32'd160);
      tx_expect(8'h3C, "tx3C");

      // Single RX frame.
      check("irq_idle", {31'd0, rx_irq}, 32'd0);
      rx_send(8'h5A, 1'b1);
      check("irq_after_rx", {31'd0, rx_irq}, 32'd1);
      rd(32'h4, "rx_data_5A", 32'h5A);
      rd(32'h0, "rx_status_after_read", 32'h0);
      check("irq_after_read", {31'd0, rx_irq}, 32'd0);

      // Overrun: two frames, no read in between.
      rx_send(8'h11, 1'b1);
      rx_send(8'h22, 1'b1);
      rd(32'h0, "overrun_status", 32'h5);
      rd(32'h4, "overrun_data", 32'h22);
      rd(32'h0, "overrun_cleared", 32'h0);

      // Framing error, then a short glitch.
      rx_send(8'h33, 1'b0);
      repeat (4) @(negedge clk);
      rd(32'h0, "frame_err_status", 32'h8);
      check("frame_err_irq", {31'd0, rx_irq}, 32'd0);
      rd(32'h0, "frame_err_cleared", 32'h0);
      @(negedge clk);
      uart_rxd = 1'b0;
      repeat (4) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (40) @(negedge clk);
      rd(32'h0, "glitch_status", 32'h0);
      check("glitch_irq", {31'd0, rx_irq}, 32'd0);

      // Reset in the middle of a TX frame.
      wr(32'h4, 32'h0000_0000);
      repeat (20) @(negedge clk);
      check("midtx_txd_low", {31'd0, uart_txd}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("midtx_reset_txd", {31'd0, uart_txd}, 32'd1);
      reset = 1'b0;
      rd(32'h0, "post_reset_status", 32'h0);
      rd(32'h8, "post_reset_divisor", 32'h1A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
